// File: rtl/dw_loader_pkg.sv
// ---------------------------------------------------------------------------
// dw_loader_pkg
// Shared definitions for the DDR region preload engine: default widths, the
// derived lane count, the loader state encoding, the canonical region order
// and the default DDR window offset.
// ---------------------------------------------------------------------------
package dw_loader_pkg;

    localparam int DEF_PORT_WIDTH = 96;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_REGION = 5;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 20;

    localparam int LANES = DEF_PORT_WIDTH / DEF_DATA_WIDTH;

    localparam logic [31:0] DEF_DDR_OFFSET = 32'h0800_0000;

    // Regions are always loaded in this index order.
    localparam int REG_CFG    = 0;
    localparam int REG_ACT    = 1;
    localparam int REG_FLGACT = 2;
    localparam int REG_WEI    = 3;
    localparam int REG_FLGWEI = 4;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        FETCH,
        SER,
        DONE
    } loader_state_t;

endpackage

// File: rtl/lane_serializer.sv
// ---------------------------------------------------------------------------
// lane_serializer
// Holds one stream word and presents it one DATA_WIDTH lane at a time,
// lowest lane first.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture load_data, present lane 0
//   load_data  : PORT_WIDTH word to serialize
//   shift      : advance to the next lane
//   lane_data  : current lane (register output)
//   last_lane  : current lane is lane PORT_WIDTH/DATA_WIDTH-1
// ---------------------------------------------------------------------------
module lane_serializer #(
    parameter int PORT_WIDTH = 96,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [PORT_WIDTH-1:0] load_data,
    input  logic                  shift,
    output logic [DATA_WIDTH-1:0] lane_data,
    output logic                  last_lane
);

    localparam int NUM_LANES = PORT_WIDTH / DATA_WIDTH;
    localparam int CW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic [PORT_WIDTH-1:0] sreg;
    logic [CW-1:0]         lane_cnt;

    // Shift right so the next lane always sits in the low bits; the counter
    // tracks which lane is currently on the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg     <= '0;
            lane_cnt <= '0;
        end else if (load) begin
            sreg     <= load_data;
            lane_cnt <= '0;
        end else if (shift) begin
            sreg     <= sreg >> DATA_WIDTH;
            lane_cnt <= lane_cnt + CW'(1);
        end
    end

    assign lane_data = sreg[DATA_WIDTH-1:0];
    assign last_lane = (lane_cnt == CW'(NUM_LANES - 1));

endmodule

// File: rtl/ddr_region_loader.sv
// ---------------------------------------------------------------------------
// ddr_region_loader
// Scatters a stream of PORT_WIDTH words into NUM_REGION memory regions as
// little-endian DATA_WIDTH lane writes. Region 0 word 0 may be replaced by
// a configuration word instead of being taken from the stream.
//   clk, rst       : clock, synchronous active-high reset
//   start          : one-cycle pulse, begins a load (ignored while busy)
//   cfg_word_en    : take region 0 word 0 from cfg_word
//   cfg_word       : override word
//   region_base    : packed per-region byte bases (DDR window addresses)
//   region_len     : packed per-region word counts, 0 skips the region
//   s_valid/s_data : stream word in, s_ready accepts it
//   mem_we/mem_addr/mem_wdata : lane write port
//   busy, done     : load in progress, one-cycle completion pulse
//   region_idx     : region currently being loaded
// ---------------------------------------------------------------------------
module ddr_region_loader
    import dw_loader_pkg::*;
#(
    parameter int PORT_WIDTH = DEF_PORT_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGION = DEF_NUM_REGION,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] DDR_OFFSET = ADDR_WIDTH'(DEF_DDR_OFFSET)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             cfg_word_en,
    input  logic [PORT_WIDTH-1:0]            cfg_word,
    input  logic [NUM_REGION*ADDR_WIDTH-1:0] region_base,
    input  logic [NUM_REGION*LEN_WIDTH-1:0]  region_len,
    input  logic                             s_valid,
    input  logic [PORT_WIDTH-1:0]            s_data,
    output logic                             s_ready,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    output logic                             busy,
    output logic                             done,
    output logic [((NUM_REGION > 1) ? $clog2(NUM_REGION) : 1)-1:0] region_idx
);

    localparam int IW = (NUM_REGION > 1) ? $clog2(NUM_REGION) : 1;
    // One extra code so the region counter can reach NUM_REGION.
    localparam int RW = $clog2(NUM_REGION + 1);

    loader_state_t         state;
    logic [RW-1:0]         r;
    logic [LEN_WIDTH-1:0]  w;
    logic [ADDR_WIDTH-1:0] addr_ptr;
    logic                  cfg_en_l;
    logic [PORT_WIDTH-1:0] cfg_word_l;
    logic [ADDR_WIDTH-1:0] base_l [NUM_REGION];
    logic [LEN_WIDTH-1:0]  len_l  [NUM_REGION];

    logic [ADDR_WIDTH-1:0] cur_base;
    logic [LEN_WIDTH-1:0]  cur_len;
    logic [LEN_WIDTH-1:0]  w_next;
    logic                  use_cfg;
    logic                  ser_load;
    logic [PORT_WIDTH-1:0] ser_load_data;
    logic                  ser_shift;
    logic                  last_lane;

    // Select the latched base and length of the current region.
    always_comb begin
        cur_base = '0;
        cur_len  = '0;
        for (int i = 0; i < NUM_REGION; i++) begin
            if (r == RW'(i)) begin
                cur_base = base_l[i];
                cur_len  = len_l[i];
            end
        end
    end

    // The override word is consumed in place of the first stream word, so
    // the FETCH cycle loads without a handshake in that case.
    always_comb begin
        w_next        = w + LEN_WIDTH'(1);
        use_cfg       = cfg_en_l && (r == RW'(REG_CFG)) && (w == '0);
        ser_load      = (state == FETCH) && (use_cfg || (s_valid && s_ready));
        ser_load_data = use_cfg ? cfg_word_l : s_data;
        ser_shift     = (state == SER) && !last_lane;
    end

    lane_serializer #(
        .PORT_WIDTH (PORT_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane_serializer (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .load_data (ser_load_data),
        .shift     (ser_shift),
        .lane_data (mem_wdata),
        .last_lane (last_lane)
    );

    // Main loader FSM. addr_ptr always holds the address of the next lane to
    // be written; it is seeded from the region base in SELECT and simply
    // increments, which wraps naturally at ADDR_WIDTH bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            r          <= '0;
            w          <= '0;
            addr_ptr   <= '0;
            cfg_en_l   <= 1'b0;
            cfg_word_l <= '0;
            for (int i = 0; i < NUM_REGION; i++) begin
                base_l[i] <= '0;
                len_l[i]  <= '0;
            end
            s_ready    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            region_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_REGION; i++) begin
                            base_l[i] <= region_base[i*ADDR_WIDTH +: ADDR_WIDTH];
                            len_l[i]  <= region_len[i*LEN_WIDTH +: LEN_WIDTH];
                        end
                        cfg_en_l   <= cfg_word_en;
                        cfg_word_l <= cfg_word;
                        r          <= '0;
                        w          <= '0;
                        busy       <= 1'b1;
                        state      <= SELECT;
                    end
                end
                SELECT: begin
                    if (r == RW'(NUM_REGION)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        region_idx <= IW'(r);
                        if (cur_len == '0) begin
                            r <= r + RW'(1);
                        end else begin
                            addr_ptr <= cur_base - DDR_OFFSET;
                            s_ready  <= !use_cfg;
                            state    <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (ser_load) begin
                        s_ready  <= 1'b0;
                        mem_we   <= 1'b1;
                        mem_addr <= addr_ptr;
                        addr_ptr <= addr_ptr + ADDR_WIDTH'(1);
                        state    <= SER;
                    end
                end
                SER: begin
                    if (!last_lane) begin
                        mem_addr <= addr_ptr;
                        addr_ptr <= addr_ptr + ADDR_WIDTH'(1);
                    end else begin
                        mem_we <= 1'b0;
                        if (w_next == cur_len) begin
                            r     <= r + RW'(1);
                            w     <= '0;
                            state <= SELECT;
                        end else begin
                            w       <= w_next;
                            s_ready <= 1'b1;
                            state   <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_region_loader.sv
// ---------------------------------------------------------------------------
// tb_ddr_region_loader
// Self-checking bench for ddr_region_loader at default parameters. A table
// of directed loads with hand-derived totals, a reset-abort sequence and a
// set of random loads are each compared against a byte-level reference
// model of where every stream byte must land.
// ---------------------------------------------------------------------------
module tb_ddr_region_loader;
    import dw_loader_pkg::*;

    localparam int NR     = 5;
    localparam int PW     = 96;
    localparam int DW     = 8;
    localparam int AW     = 32;
    localparam int LW     = 20;
    localparam int IW     = 3;
    localparam int BUDGET = 2000;
    localparam logic [31:0] OFF = 32'h0800_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             cfg_word_en = 1'b0;
    logic [PW-1:0]    cfg_word = '0;
    logic [NR*AW-1:0] region_base = '0;
    logic [NR*LW-1:0] region_len = '0;
    logic             s_valid = 1'b0;
    logic [PW-1:0]    s_data = '0;
    logic             s_ready;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic             busy;
    logic             done;
    logic [IW-1:0]    region_idx;

    ddr_region_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_word_en (cfg_word_en),
        .cfg_word    (cfg_word),
        .region_base (region_base),
        .region_len  (region_len),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .done        (done),
        .region_idx  (region_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          region;
    } wr_t;

    typedef struct {
        logic [8*12-1:0] name;
        logic [NR*AW-1:0] bases;
        logic [NR*LW-1:0] lens;
        bit               cfg_en;
        logic [PW-1:0]    cfg;
        int               stall;
        int               exp_writes;
        int               exp_consumed;
        int               exp_lat;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [NR*AW-1:0] cur_bases;
    logic [NR*LW-1:0] cur_lens;
    bit               cur_cfg_en;
    logic [PW-1:0]    cur_cfg;
    logic [PW-1:0]    stream_q[$];
    wr_t              exp_q[$];
    wr_t              got_q[$];
    vec_t             tv[5];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [NR*LW-1:0] pack_len(input int l0, input int l1, input int l2,
                                                  input int l3, input int l4);
        logic [NR*LW-1:0] p;
        p = '0;
        p[REG_CFG*LW +: LW]    = LW'(l0);
        p[REG_ACT*LW +: LW]    = LW'(l1);
        p[REG_FLGACT*LW +: LW] = LW'(l2);
        p[REG_WEI*LW +: LW]    = LW'(l3);
        p[REG_FLGWEI*LW +: LW] = LW'(l4);
        return p;
    endfunction

    function automatic logic [PW-1:0] rand_word();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Fill the stream with enough random words for the current lengths.
    task automatic fill_stream();
        int total;
        total = 0;
        for (int r = 0; r < NR; r++) total += int'(cur_lens[r*LW +: LW]);
        stream_q.delete();
        for (int i = 0; i < total + 2; i++) stream_q.push_back(rand_word());
    endtask

    // Reference model: walk regions in order, take each word from the
    // override or the next stream entry, and emit its bytes low first at
    // consecutive addresses from the offset-adjusted base.
    task automatic build_expected(output int n_consumed);
        int k;
        logic [31:0] base_eff;
        logic [PW-1:0] word;
        int len;
        exp_q.delete();
        k = 0;
        for (int r = 0; r < NR; r++) begin
            len = int'(cur_lens[r*LW +: LW]);
            base_eff = cur_bases[r*AW +: AW] - OFF;
            for (int w = 0; w < len; w++) begin
                if (r == REG_CFG && w == 0 && cur_cfg_en) word = cur_cfg;
                else begin
                    word = stream_q[k];
                    k++;
                end
                for (int i = 0; i < LANES; i++)
                    exp_q.push_back('{base_eff + 32'(w * LANES + i), word[i*8 +: 8], r});
            end
        end
        n_consumed = k;
    endtask

    // Launch one load and record every write until done (plus a few cycles
    // afterwards to catch stray writes or a second done pulse).
    task automatic apply_stimulus(input int stall_mode, input bit poke_start,
                                  output int consumed, output int latency,
                                  output int done_cnt, output int we_stalled);
        int c;
        int k;
        bit fin;
        got_q.delete();
        consumed = 0; latency = -1; done_cnt = 0; we_stalled = 0; k = 0; fin = 0;
        @(posedge clk); #1;
        region_base = cur_bases;
        region_len  = cur_lens;
        cfg_word_en = cur_cfg_en;
        cfg_word    = cur_cfg;
        s_valid     = 1'b0;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while (!fin && c < BUDGET) begin
            case (stall_mode)
                0:       s_valid = 1'b1;
                1:       s_valid = ($urandom_range(0, 2) != 0);
                default: s_valid = ((c % 4) == 0) || ((c % 4) == 3);
            endcase
            s_data = (k < stream_q.size()) ? stream_q[k] : '0;
            start  = poke_start && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            if (mem_we) got_q.push_back('{mem_addr, mem_wdata, int'(region_idx)});
            if (mem_we && s_ready) we_stalled++;
            if (s_valid && s_ready) begin
                k++;
                consumed++;
            end
            if (done) begin
                done_cnt++;
                latency = c;
                fin = 1;
            end
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        s_valid = 1'b0;
        if (!fin) check_output("done_timeout", 64'(c), 64'(BUDGET + 1));
        repeat (4) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (mem_we) got_q.push_back('{mem_addr, mem_wdata, int'(region_idx)});
        end
    endtask

    task automatic compare_run(input string name, input int consumed, input int latency,
                               input int done_cnt, input int we_stalled,
                               input int exp_writes, input int exp_consumed, input int exp_lat);
        int n;
        check_output({name, ".writes"}, 64'(got_q.size()), 64'(exp_writes));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_output($sformatf("%s.wr%0d", name, i),
                         {got_q[i].addr, got_q[i].data, 8'(got_q[i].region), 16'h0},
                         {exp_q[i].addr, exp_q[i].data, 8'(exp_q[i].region), 16'h0});
        check_output({name, ".consumed"}, 64'(consumed), 64'(exp_consumed));
        check_output({name, ".done_pulses"}, 64'(done_cnt), 64'd1);
        check_output({name, ".we_while_ready"}, 64'(we_stalled), 64'd0);
        if (exp_lat >= 0) check_output({name, ".latency"}, 64'(latency), 64'(exp_lat));
        check_output({name, ".idle_after"}, {62'd0, busy, s_ready}, 64'd0);
    endtask

    initial begin
        int cons, lat, dc, ws, mc, nw;
        logic [PW-1:0] cfg_ovr;
        cfg_ovr = PW'({4'd15, 5'd31, 5'd1, 5'd15, 8'd15, 8'd7, 9'd10});

        tv[0] = '{"single",    '0, pack_len(1, 0, 0, 0, 0), 0, '0, 0, 12, 1, 19};
        tv[0].bases[REG_CFG*AW +: AW] = 32'h0800_0010;
        tv[1] = '{"cfg_ovr",   '0, pack_len(2, 0, 0, 0, 0), 1, cfg_ovr, 0, 24, 1, 32};
        tv[1].bases[REG_CFG*AW +: AW] = 32'h0800_1000;
        tv[2] = '{"five_reg",  '0, pack_len(1, 0, 3, 2, 1), 0, '0, 0, 84, 7, 97};
        for (int r = 0; r < NR; r++) tv[2].bases[r*AW +: AW] = OFF + 32'(32'h1000 * (r + 1));
        tv[3] = '{"wrap",      '0, pack_len(1, 0, 0, 0, 0), 0, '0, 0, 12, 1, 19};
        tv[3].bases[REG_CFG*AW +: AW] = 32'h07FF_FFFC;
        tv[4] = '{"backpress", '0, pack_len(0, 3, 0, 1, 0), 0, '0, 2, 48, 4, -1};
        tv[4].bases[REG_ACT*AW +: AW] = 32'h0800_2000;
        tv[4].bases[REG_WEI*AW +: AW] = 32'h0800_3000;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_outputs",
                     {s_ready, mem_we, mem_addr, mem_wdata, busy, done, region_idx, 17'd0}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed table
        for (int t = 0; t < 5; t++) begin
            cur_bases  = tv[t].bases;
            cur_lens   = tv[t].lens;
            cur_cfg_en = tv[t].cfg_en;
            cur_cfg    = tv[t].cfg;
            fill_stream();
            if (t == 0) stream_q[0] = 96'h0C0B_0A09_0807_0605_0403_0201;
            build_expected(mc);
            apply_stimulus(tv[t].stall, 1'b0, cons, lat, dc, ws);
            compare_run($sformatf("%0s", tv[t].name), cons, lat, dc, ws,
                        tv[t].exp_writes, tv[t].exp_consumed, tv[t].exp_lat);
        end

        // Reset in the middle of serializing lane 5 of the first word
        cur_bases  = '0;
        cur_bases[REG_CFG*AW +: AW] = 32'h0800_0400;
        cur_bases[REG_ACT*AW +: AW] = 32'h0800_0800;
        cur_lens   = pack_len(2, 1, 0, 0, 0);
        cur_cfg_en = 0;
        cur_cfg    = '0;
        fill_stream();
        @(posedge clk); #1;
        region_base = cur_bases;
        region_len  = cur_lens;
        cfg_word_en = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = stream_q[0];
        nw = 0;
        for (int c = 0; c < 100 && nw < 6; c++) begin
            @(negedge clk);
            if (mem_we) nw++;
        end
        check_output("rst.reached_lane5", 64'(nw), 64'd6);
        rst = 1'b1;
        @(negedge clk);
        check_output("rst.outputs", {59'd0, mem_we, busy, done, s_ready, 1'b0}, 64'd0);
        rst = 1'b0;
        s_valid = 1'b0;
        nw = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_we || done || busy) nw++;
        end
        check_output("rst.quiet", 64'(nw), 64'd0);
        fill_stream();
        build_expected(mc);
        apply_stimulus(0, 1'b0, cons, lat, dc, ws);
        compare_run("rst.reload", cons, lat, dc, ws, 36, 3, 5 + 1 + 3 * 13);

        // Random loads against the model, with stray start pulses while busy
        for (int t = 0; t < 6; t++) begin
            for (int r = 0; r < NR; r++) cur_bases[r*AW +: AW] = $urandom;
            cur_lens = pack_len($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                                $urandom_range(0, 3), $urandom_range(0, 3));
            if (cur_lens == '0) cur_lens[REG_WEI*LW +: LW] = LW'(2);
            cur_cfg_en = $urandom_range(0, 1) == 1;
            cur_cfg    = rand_word();
            fill_stream();
            build_expected(mc);
            apply_stimulus(1, 1'b1, cons, lat, dc, ws);
            compare_run($sformatf("rand%0d", t), cons, lat, dc, ws, exp_q.size(), mc, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
